vliw_issue_scoreboard: RTL and testbench

Issue controller for the 3-slot VLIW register-read stage. It accepts one instruction bundle at a time from fetch, checks every slot against a 16-entry pending-write scoreboard, and releases slots in order to the register file. Slots are released only when their operands and destination are free. Bundles with duplicate destinations are split across cycles. The scoreboard is cleared by the three writeback ports.

---
 rtl/vliw_issue_scoreboard_pkg.sv | 33 +++
 rtl/vliw_issue_scoreboard_if.sv | 54 +++++
 rtl/vliw_issue_scoreboard_scoreboard_bits.sv | 41 ++++
 rtl/vliw_issue_scoreboard.sv | 168 ++++++++++++++++
 tb/tb_vliw_issue_scoreboard.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vliw_issue_scoreboard_pkg.sv
// Shared definitions for the VLIW issue scoreboard: opcode classes,
// operand-usage helpers and the controller state encoding.
package vliw_issue_scoreboard_pkg;

  localparam int NSLOT = 3;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h4;
  localparam logic [3:0] OP_UNARY0 = 4'h5;
  localparam logic [3:0] OP_UNARY1 = 4'h6;
  localparam logic [3:0] OP_UNARY2 = 4'hB;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  // Every real opcode except load reads src1.
  function automatic logic uses_src1(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_LOAD);
  endfunction

  // Unary opcodes read only src1; everything else that reads src1 reads src2.
  function automatic logic uses_src2(input logic [3:0] op);
    return uses_src1(op) && (op != OP_UNARY0) && (op != OP_UNARY1) && (op != OP_UNARY2);
  endfunction

  // Every non-NOP opcode produces a register result.
  function automatic logic writes_dest(input logic [3:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/vliw_issue_scoreboard_if.sv
// Fetch / writeback / register-stage bundle between the issue controller
// and its neighbours. master = environment side, slave = controller side.
interface vliw_issue_scoreboard_if #(
  parameter int NREG   = 16,
  parameter int SCNT_W = 16
);
  logic              flush;
  logic              bnd_valid;
  logic              bnd_ready;
  logic [3:0]        f2s_instpipe1, f2s_instpipe2, f2s_instpipe3;
  logic [3:0]        f2s_src1pipe1, f2s_src1pipe2, f2s_src1pipe3;
  logic [3:0]        f2s_src2pipe1, f2s_src2pipe2, f2s_src2pipe3;
  logic [3:0]        f2s_destpipe1, f2s_destpipe2, f2s_destpipe3;
  logic              w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3;
  logic [3:0]        w2re_destpipe1, w2re_destpipe2, w2re_destpipe3;
  logic              iss_validpipe1, iss_validpipe2, iss_validpipe3;
  logic [3:0]        iss_instpipe1, iss_instpipe2, iss_instpipe3;
  logic [3:0]        iss_src1pipe1, iss_src1pipe2, iss_src1pipe3;
  logic [3:0]        iss_src2pipe1, iss_src2pipe2, iss_src2pipe3;
  logic [NREG-1:0]   pending;
  logic [SCNT_W-1:0] stall_count;

  modport master (
    output flush, bnd_valid,
    output f2s_instpipe1, f2s_instpipe2, f2s_instpipe3,
    output f2s_src1pipe1, f2s_src1pipe2, f2s_src1pipe3,
    output f2s_src2pipe1, f2s_src2pipe2, f2s_src2pipe3,
    output f2s_destpipe1, f2s_destpipe2, f2s_destpipe3,
    output w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3,
    output w2re_destpipe1, w2re_destpipe2, w2re_destpipe3,
    input  bnd_ready,
    input  iss_validpipe1, iss_validpipe2, iss_validpipe3,
    input  iss_instpipe1, iss_instpipe2, iss_instpipe3,
    input  iss_src1pipe1, iss_src1pipe2, iss_src1pipe3,
    input  iss_src2pipe1, iss_src2pipe2, iss_src2pipe3,
    input  pending, stall_count
  );

  modport slave (
    input  flush, bnd_valid,
    input  f2s_instpipe1, f2s_instpipe2, f2s_instpipe3,
    input  f2s_src1pipe1, f2s_src1pipe2, f2s_src1pipe3,
    input  f2s_src2pipe1, f2s_src2pipe2, f2s_src2pipe3,
    input  f2s_destpipe1, f2s_destpipe2, f2s_destpipe3,
    input  w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3,
    input  w2re_destpipe1, w2re_destpipe2, w2re_destpipe3,
    output bnd_ready,
    output iss_validpipe1, iss_validpipe2, iss_validpipe3,
    output iss_instpipe1, iss_instpipe2, iss_instpipe3,
    output iss_src1pipe1, iss_src1pipe2, iss_src1pipe3,
    output iss_src2pipe1, iss_src2pipe2, iss_src2pipe3,
    output pending, stall_count
  );
endinterface

// File: rtl/vliw_issue_scoreboard_scoreboard_bits.sv
// Pending-write bit vector: three set ports (issued writers) and three
// clear ports (writebacks). A set and a clear to the same bit in one
// cycle leaves the bit set, since the new writer is still in flight.
module scoreboard_bits #(
  parameter int NREG  = 16,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:1]            set_en,
  input  logic [3:1][IDX_W-1:0] set_idx,
  input  logic [3:1]            clr_en,
  input  logic [3:1][IDX_W-1:0] clr_idx,
  output logic [NREG-1:0]       pending
);

  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      logic [3:1] set_match;
      logic [3:1] clr_match;
      for (gj = 1; gj <= 3; gj++) begin : g_port
        assign set_match[gj] = set_en[gj] && (set_idx[gj] == IDX_W'(gi));
        assign clr_match[gj] = clr_en[gj] && (clr_idx[gj] == IDX_W'(gi));
      end
      assign pending_next[gi] = (|set_match) | (pending_reg[gi] & ~(|clr_match));
    end
  endgenerate

  // Scoreboard state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending_reg <= '0;
    else       pending_reg <= pending_next;
  end

  assign pending = pending_reg;

endmodule

// File: rtl/vliw_issue_scoreboard.sv
// Issue controller for the 3-slot VLIW register-read stage. Holds one
// bundle, releases the longest hazard-free in-order prefix of its
// remaining slots each cycle, and tracks in-flight writes.
module vliw_issue_scoreboard
  import vliw_issue_scoreboard_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int SCNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  vliw_issue_scoreboard_if.slave bus
);

  // Slot-indexed views of the fetch and writeback buses.
  logic [3:0]      f_inst [1:3];
  logic [3:0]      f_src1 [1:3];
  logic [3:0]      f_src2 [1:3];
  logic [3:0]      f_dest [1:3];
  logic [3:1]      wb_en;
  logic [3:1][3:0] wb_idx;

  assign f_inst[1] = bus.f2s_instpipe1;
  assign f_inst[2] = bus.f2s_instpipe2;
  assign f_inst[3] = bus.f2s_instpipe3;
  assign f_src1[1] = bus.f2s_src1pipe1;
  assign f_src1[2] = bus.f2s_src1pipe2;
  assign f_src1[3] = bus.f2s_src1pipe3;
  assign f_src2[1] = bus.f2s_src2pipe1;
  assign f_src2[2] = bus.f2s_src2pipe2;
  assign f_src2[3] = bus.f2s_src2pipe3;
  assign f_dest[1] = bus.f2s_destpipe1;
  assign f_dest[2] = bus.f2s_destpipe2;
  assign f_dest[3] = bus.f2s_destpipe3;
  assign wb_en     = {bus.w2r_wrpipe3, bus.w2r_wrpipe2, bus.w2r_wrpipe1};
  assign wb_idx    = {bus.w2re_destpipe3, bus.w2re_destpipe2, bus.w2re_destpipe1};

  state_t            state_reg;
  logic [3:1]        rem_reg;
  logic [3:1]        rem_next;
  logic [3:0]        h_inst_reg [1:3];
  logic [3:0]        h_src1_reg [1:3];
  logic [3:0]        h_src2_reg [1:3];
  logic [3:0]        h_dest_reg [1:3];
  logic [3:1]        iss_valid_reg;
  logic [3:0]        iss_inst_reg [1:3];
  logic [3:0]        iss_src1_reg [1:3];
  logic [3:0]        iss_src2_reg [1:3];
  logic [SCNT_W-1:0] stall_reg;

  logic [NREG-1:0]   pending;
  logic [3:1]        haz;
  logic [3:1]        waw;
  logic [3:1]        rel;
  logic [3:1]        nonnop;
  logic [3:1]        set_en;
  logic [3:1][3:0]   set_idx;
  logic              accept;
  logic              stall_inc;

  genvar gi;
  generate
    for (gi = 1; gi <= NSLOT; gi++) begin : g_slot
      logic waw_hit;
      // Same destination as any lower slot still waiting in this bundle.
      always_comb begin
        waw_hit = 1'b0;
        for (int m = 1; m < gi; m++) begin
          if (rem_reg[m] && (h_dest_reg[m] == h_dest_reg[gi])) waw_hit = 1'b1;
        end
      end
      assign waw[gi]     = waw_hit;
      assign haz[gi]     = (uses_src1(h_inst_reg[gi]) && pending[h_src1_reg[gi]]) ||
                           (uses_src2(h_inst_reg[gi]) && pending[h_src2_reg[gi]]) ||
                           (writes_dest(h_inst_reg[gi]) && pending[h_dest_reg[gi]]);
      assign nonnop[gi]  = (f_inst[gi] != OP_NOP);
      assign set_en[gi]  = rel[gi] && writes_dest(h_inst_reg[gi]);
      assign set_idx[gi] = h_dest_reg[gi];
    end
  endgenerate

  // In-order release: the first blocked remaining slot stops all higher slots.
  always_comb begin
    logic blocked;
    rel     = '0;
    blocked = 1'b0;
    for (int n = 1; n <= NSLOT; n++) begin
      if (rem_reg[n]) begin
        if (!blocked && !haz[n] && !waw[n] && !bus.flush) rel[n] = 1'b1;
        else                                               blocked = 1'b1;
      end
    end
  end

  assign rem_next  = rem_reg & ~rel;
  assign accept    = bus.bnd_valid && (state_reg == ST_EMPTY) && !bus.flush;
  assign stall_inc = (state_reg == ST_HELD) && !bus.flush && (rel == '0) && (stall_reg != '1);

  // Controller FSM: bundle capture, remaining mask, registered issue outputs, stall counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_EMPTY;
      rem_reg       <= '0;
      iss_valid_reg <= '0;
      stall_reg     <= '0;
      for (int n = 1; n <= NSLOT; n++) begin
        h_inst_reg[n]   <= '0;
        h_src1_reg[n]   <= '0;
        h_src2_reg[n]   <= '0;
        h_dest_reg[n]   <= '0;
        iss_inst_reg[n] <= '0;
        iss_src1_reg[n] <= '0;
        iss_src2_reg[n] <= '0;
      end
    end else begin
      iss_valid_reg <= rel;
      for (int n = 1; n <= NSLOT; n++) begin
        iss_inst_reg[n] <= rel[n] ? h_inst_reg[n] : OP_NOP;
        iss_src1_reg[n] <= rel[n] ? h_src1_reg[n] : 4'h0;
        iss_src2_reg[n] <= rel[n] ? h_src2_reg[n] : 4'h0;
      end
      if (bus.flush) begin
        rem_reg   <= '0;
        state_reg <= ST_EMPTY;
      end else if (accept) begin
        for (int n = 1; n <= NSLOT; n++) begin
          h_inst_reg[n] <= f_inst[n];
          h_src1_reg[n] <= f_src1[n];
          h_src2_reg[n] <= f_src2[n];
          h_dest_reg[n] <= f_dest[n];
        end
        rem_reg   <= nonnop;
        state_reg <= (nonnop != '0) ? ST_HELD : ST_EMPTY;
      end else if (state_reg == ST_HELD) begin
        rem_reg   <= rem_next;
        state_reg <= (rem_next == '0) ? ST_EMPTY : ST_HELD;
      end
      if (stall_inc) stall_reg <= stall_reg + SCNT_W'(1);
    end
  end

  scoreboard_bits #(.NREG(NREG), .IDX_W(4)) u_scoreboard_bits (
    .clock   (clock),
    .reset   (reset),
    .set_en  (set_en),
    .set_idx (set_idx),
    .clr_en  (wb_en),
    .clr_idx (wb_idx),
    .pending (pending)
  );

  assign bus.bnd_ready      = (state_reg == ST_EMPTY) | bus.flush;
  assign bus.pending        = pending;
  assign bus.stall_count    = stall_reg;
  assign bus.iss_validpipe1 = iss_valid_reg[1];
  assign bus.iss_validpipe2 = iss_valid_reg[2];
  assign bus.iss_validpipe3 = iss_valid_reg[3];
  assign bus.iss_instpipe1  = iss_inst_reg[1];
  assign bus.iss_instpipe2  = iss_inst_reg[2];
  assign bus.iss_instpipe3  = iss_inst_reg[3];
  assign bus.iss_src1pipe1  = iss_src1_reg[1];
  assign bus.iss_src1pipe2  = iss_src1_reg[2];
  assign bus.iss_src1pipe3  = iss_src1_reg[3];
  assign bus.iss_src2pipe1  = iss_src2_reg[1];
  assign bus.iss_src2pipe2  = iss_src2_reg[2];
  assign bus.iss_src2pipe3  = iss_src2_reg[3];

endmodule

// File: tb/tb_vliw_issue_scoreboard.sv
// Self-checking bench for vliw_issue_scoreboard: directed scenarios plus
// randomized traffic, all checked against a queue-based behavioural model.
module tb_vliw_issue_scoreboard;

  localparam int NREG   = 16;
  localparam int SCNT_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vliw_issue_scoreboard_if #(.NREG(NREG), .SCNT_W(SCNT_W)) bus ();

  vliw_issue_scoreboard #(.NREG(NREG), .SCNT_W(SCNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: queue of remaining non-NOP slots in slot order, pending set, stall count.
  typedef struct {
    logic [3:0] op, s1, s2, d;
    int         slot;
  } slot_t;
  slot_t       mq[$];
  logic [15:0] mp = 16'h0;
  int          ms = 0;

  // Stimulus for the next cycle; bundle word = {op, src1, src2, dest}.
  logic [15:0] cur_b [1:3];
  logic        cur_valid = 1'b0;
  logic        cur_flush = 1'b0;
  logic        cur_wr [1:3];
  logic [3:0]  cur_wd [1:3];

  function automatic logic [15:0] ins(input logic [3:0] op, s1, s2, d);
    return {op, s1, s2, d};
  endfunction

  function automatic bit m_src1(input logic [3:0] op);
    return !(op == 4'h0 || op == 4'h4);
  endfunction

  function automatic bit m_src2(input logic [3:0] op);
    return m_src1(op) && !(op == 4'h5 || op == 4'h6 || op == 4'hB);
  endfunction

  task automatic apply();
    bus.bnd_valid      = cur_valid;
    bus.flush          = cur_flush;
    bus.f2s_instpipe1  = cur_b[1][15:12];
    bus.f2s_src1pipe1  = cur_b[1][11:8];
    bus.f2s_src2pipe1  = cur_b[1][7:4];
    bus.f2s_destpipe1  = cur_b[1][3:0];
    bus.f2s_instpipe2  = cur_b[2][15:12];
    bus.f2s_src1pipe2  = cur_b[2][11:8];
    bus.f2s_src2pipe2  = cur_b[2][7:4];
    bus.f2s_destpipe2  = cur_b[2][3:0];
    bus.f2s_instpipe3  = cur_b[3][15:12];
    bus.f2s_src1pipe3  = cur_b[3][11:8];
    bus.f2s_src2pipe3  = cur_b[3][7:4];
    bus.f2s_destpipe3  = cur_b[3][3:0];
    bus.w2r_wrpipe1    = cur_wr[1];
    bus.w2r_wrpipe2    = cur_wr[2];
    bus.w2r_wrpipe3    = cur_wr[3];
    bus.w2re_destpipe1 = cur_wd[1];
    bus.w2re_destpipe2 = cur_wd[2];
    bus.w2re_destpipe3 = cur_wd[3];
  endtask

  task automatic clear_stim();
    for (int p = 1; p <= 3; p++) begin
      cur_b[p]  = 16'h0;
      cur_wr[p] = 1'b0;
      cur_wd[p] = 4'h0;
    end
    cur_valid = 1'b0;
    cur_flush = 1'b0;
  endtask

  // One clock cycle: model predicts, edge happens, DUT outputs are compared.
  task automatic step();
    logic [15:0] setm, clrm, seen, exp_p;
    logic        ev [1:3];
    logic [3:0]  ei [1:3], e1 [1:3], e2 [1:3];
    logic        ov [1:3];
    logic [3:0]  oi [1:3], o1 [1:3], o2 [1:3];
    int          nrel, exp_s;
    bit          stop, blk, was_empty, exp_ready;
    slot_t       s;
    apply();
    #1;
    was_empty = (mq.size() == 0);
    exp_ready = was_empty || cur_flush;
    checks++;
    if (bus.bnd_ready !== exp_ready) begin
      failures++;
      $display("FAIL bnd_ready t=%0t got=%b expected=%b", $time, bus.bnd_ready, exp_ready);
    end
    setm = '0; clrm = '0; seen = '0; nrel = 0; stop = 0;
    for (int p = 1; p <= 3; p++) begin
      ev[p] = 1'b0; ei[p] = 4'h0; e1[p] = 4'h0; e2[p] = 4'h0;
    end
    if (!cur_flush) begin
      for (int k = 0; k < mq.size(); k++) begin
        if (!stop) begin
          s   = mq[k];
          blk = (m_src1(s.op) && mp[s.s1]) || (m_src2(s.op) && mp[s.s2]) || mp[s.d] || seen[s.d];
          if (blk) stop = 1;
          else begin
            nrel++;
            ev[s.slot] = 1'b1; ei[s.slot] = s.op; e1[s.slot] = s.s1; e2[s.slot] = s.s2;
            setm[s.d] = 1'b1;
          end
          seen[s.d] = 1'b1;
        end
      end
    end
    for (int p = 1; p <= 3; p++) if (cur_wr[p]) clrm[cur_wd[p]] = 1'b1;
    exp_p = (mp & ~clrm) | setm;
    exp_s = ms;
    if (!was_empty && !cur_flush && nrel == 0 && ms < 15) exp_s++;
    if (cur_flush) mq.delete();
    else for (int k = 0; k < nrel; k++) s = mq.pop_front();
    if (cur_valid && was_empty && !cur_flush) begin
      for (int p = 1; p <= 3; p++) begin
        if (cur_b[p][15:12] != 4'h0) begin
          s.op = cur_b[p][15:12]; s.s1 = cur_b[p][11:8];
          s.s2 = cur_b[p][7:4];   s.d  = cur_b[p][3:0];
          s.slot = p;
          mq.push_back(s);
        end
      end
    end
    @(posedge clock);
    #1;
    mp = exp_p;
    ms = exp_s;
    ov[1] = bus.iss_validpipe1; oi[1] = bus.iss_instpipe1; o1[1] = bus.iss_src1pipe1; o2[1] = bus.iss_src2pipe1;
    ov[2] = bus.iss_validpipe2; oi[2] = bus.iss_instpipe2; o1[2] = bus.iss_src1pipe2; o2[2] = bus.iss_src2pipe2;
    ov[3] = bus.iss_validpipe3; oi[3] = bus.iss_instpipe3; o1[3] = bus.iss_src1pipe3; o2[3] = bus.iss_src2pipe3;
    for (int p = 1; p <= 3; p++) begin
      checks++;
      if (ov[p] !== ev[p] || oi[p] !== ei[p] || o1[p] !== e1[p] || o2[p] !== e2[p]) begin
        failures++;
        $display("FAIL iss_slot%0d t=%0t got v=%b op=%h s1=%h s2=%h expected v=%b op=%h s1=%h s2=%h",
                 p, $time, ov[p], oi[p], o1[p], o2[p], ev[p], ei[p], e1[p], e2[p]);
      end
    end
    checks++;
    if (bus.pending !== mp) begin
      failures++;
      $display("FAIL pending t=%0t got=%h expected=%h", $time, bus.pending, mp);
    end
    checks++;
    if (bus.stall_count !== SCNT_W'(ms)) begin
      failures++;
      $display("FAIL stall_count t=%0t got=%0d expected=%0d", $time, bus.stall_count, ms);
    end
    $display("cycle t=%0t valid=%b flush=%b rel=%b%b%b pending=%h stall=%0d held=%0d",
             $time, cur_valid, cur_flush, ov[1], ov[2], ov[3], bus.pending, bus.stall_count, mq.size());
    cur_valid = 1'b0;
    cur_flush = 1'b0;
    for (int p = 1; p <= 3; p++) cur_wr[p] = 1'b0;
  endtask

  // Retire every in-flight write (and let any held bundle drain).
  task automatic clear_pending();
    int it = 0;
    while ((mp != 16'h0 || mq.size() != 0) && it < 40) begin
      int p = 1;
      for (int r = 0; r < 16; r++) begin
        if (mp[r] && p <= 3) begin
          cur_wr[p] = 1'b1; cur_wd[p] = 4'(r); p++;
        end
      end
      step();
      it++;
    end
    checks++;
    if (mp != 16'h0 || mq.size() != 0 || bus.pending !== 16'h0) begin
      failures++;
      $display("FAIL drain got pending=%h held=%0d expected pending=0000 held=0", bus.pending, mq.size());
    end
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.bnd_ready !== 1'b1 || bus.pending !== 16'h0 || bus.stall_count !== 4'h0 ||
        {bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3} !== 3'b000 ||
        {bus.iss_instpipe1, bus.iss_instpipe2, bus.iss_instpipe3} !== 12'h0 ||
        {bus.iss_src1pipe1, bus.iss_src1pipe2, bus.iss_src1pipe3} !== 12'h0 ||
        {bus.iss_src2pipe1, bus.iss_src2pipe2, bus.iss_src2pipe3} !== 12'h0) begin
      failures++;
      $display("FAIL reset_state got ready=%b pending=%h stall=%0d valid=%b%b%b expected ready=1 pending=0000 stall=0 valid=000",
               bus.bnd_ready, bus.pending, bus.stall_count,
               bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3);
    end
    mq.delete();
    mp = 16'h0;
    ms = 0;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
  endtask

  task automatic test_independent();
    cur_b[1] = ins(4'h1, 4'd2, 4'd3, 4'd1);
    cur_b[2] = ins(4'h2, 4'd5, 4'd6, 4'd4);
    cur_b[3] = ins(4'h4, 4'd0, 4'd0, 4'd7);
    cur_valid = 1'b1;
    step();
    step();
    checks++;
    if ({bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3} !== 3'b111 || bus.pending !== 16'h0092) begin
      failures++;
      $display("FAIL independent got valid=%b%b%b pending=%h expected valid=111 pending=0092",
               bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3, bus.pending);
    end
    clear_pending();
  endtask

  task automatic test_raw();
    int s0;
    clear_stim();
    cur_b[1] = ins(4'h1, 4'd0, 4'd0, 4'd4);
    cur_valid = 1'b1;
    step();
    step();
    cur_b[1] = ins(4'h1, 4'd4, 4'd1, 4'd8);
    cur_valid = 1'b1;
    step();
    s0 = ms;
    step(); step(); step();
    checks++;
    if (bus.stall_count !== SCNT_W'(s0 + 3) || bus.iss_validpipe1 !== 1'b0) begin
      failures++;
      $display("FAIL raw_stall got stall=%0d valid1=%b expected stall=%0d valid1=0",
               bus.stall_count, bus.iss_validpipe1, s0 + 3);
    end
    cur_wr[2] = 1'b1; cur_wd[2] = 4'd4;
    step();
    checks++;
    if (bus.iss_validpipe1 !== 1'b0) begin
      failures++;
      $display("FAIL raw_no_bypass got valid1=%b expected valid1=0", bus.iss_validpipe1);
    end
    step();
    checks++;
    if (bus.iss_validpipe1 !== 1'b1 || bus.iss_src1pipe1 !== 4'd4) begin
      failures++;
      $display("FAIL raw_release got valid1=%b src1=%h expected valid1=1 src1=4",
               bus.iss_validpipe1, bus.iss_src1pipe1);
    end
    clear_pending();
  endtask

  task automatic test_waw();
    clear_stim();
    cur_b[1] = ins(4'h1, 4'd0, 4'd0, 4'd9);
    cur_b[2] = ins(4'h2, 4'd0, 4'd0, 4'd2);
    cur_b[3] = ins(4'h3, 4'd0, 4'd0, 4'd9);
    cur_valid = 1'b1;
    step();
    step();
    checks++;
    if ({bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3} !== 3'b110) begin
      failures++;
      $display("FAIL waw_first got valid=%b%b%b expected valid=110",
               bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3);
    end
    step();
    cur_wr[1] = 1'b1; cur_wd[1] = 4'd9;
    step();
    step();
    checks++;
    if ({bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3} !== 3'b001 || bus.iss_instpipe3 !== 4'h3) begin
      failures++;
      $display("FAIL waw_second got valid=%b%b%b op3=%h expected valid=001 op3=3",
               bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3, bus.iss_instpipe3);
    end
    clear_pending();
  endtask

  task automatic test_collision();
    clear_stim();
    cur_b[1] = ins(4'h4, 4'd0, 4'd0, 4'd5);
    cur_valid = 1'b1;
    step();
    cur_wr[3] = 1'b1; cur_wd[3] = 4'd5;
    step();
    checks++;
    if (bus.pending[5] !== 1'b1 || bus.iss_validpipe1 !== 1'b1) begin
      failures++;
      $display("FAIL set_wins got pending5=%b valid1=%b expected pending5=1 valid1=1",
               bus.pending[5], bus.iss_validpipe1);
    end
    clear_pending();
  endtask

  task automatic test_flush();
    logic [15:0] p_before;
    clear_stim();
    cur_b[1] = ins(4'h4, 4'd0, 4'd0, 4'd10);
    cur_valid = 1'b1;
    step();
    step();
    cur_b[1] = 16'h0;
    cur_b[2] = ins(4'h1, 4'd10, 4'd0, 4'd11);
    cur_b[3] = ins(4'h4, 4'd0, 4'd0, 4'd12);
    cur_valid = 1'b1;
    step();
    step();
    p_before = mp;
    cur_b[1] = ins(4'h4, 4'd0, 4'd0, 4'd13);
    cur_b[2] = 16'h0;
    cur_b[3] = 16'h0;
    cur_valid = 1'b1;
    cur_flush = 1'b1;
    step();
    apply();
    #1;
    checks++;
    if (bus.bnd_ready !== 1'b1 || bus.pending !== p_before ||
        {bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3} !== 3'b000) begin
      failures++;
      $display("FAIL flush got ready=%b pending=%h valid=%b%b%b expected ready=1 pending=%h valid=000",
               bus.bnd_ready, bus.pending, bus.iss_validpipe1, bus.iss_validpipe2, bus.iss_validpipe3, p_before);
    end
    step();
    clear_pending();
  endtask

  task automatic test_saturation();
    clear_stim();
    cur_b[1] = ins(4'h4, 4'd0, 4'd0, 4'd3);
    cur_valid = 1'b1;
    step();
    step();
    cur_b[1] = ins(4'h4, 4'd0, 4'd0, 4'd3);
    cur_valid = 1'b1;
    step();
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (bus.stall_count !== 4'hF) begin
      failures++;
      $display("FAIL stall_saturate got=%0d expected=15", bus.stall_count);
    end
    do_reset();
    clear_stim();
    step();
  endtask

  task automatic test_random();
    clear_stim();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        cur_valid = 1'b1;
        for (int p = 1; p <= 3; p++) begin
          cur_b[p] = ins(($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                         4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
        end
      end
      cur_flush = ($urandom_range(0, 31) == 0);
      for (int p = 1; p <= 3; p++) begin
        cur_wr[p] = ($urandom_range(0, 2) == 0);
        cur_wd[p] = 4'($urandom_range(0, 7));
      end
      step();
    end
    clear_pending();
  endtask

  initial begin
    clear_stim();
    apply();
    #16;
    test_reset();
    test_independent();
    test_raw();
    test_waw();
    test_collision();
    test_flush();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
